// File: rtl/led_sipo_rx.sv
// led_sipo_rx: serial-to-parallel LED frame receiver.
//   Captures an LSB-first serial stream framed by an active-low latch strobe,
//   checks the frame length, optionally swaps the two halves back, and holds
//   the last good pattern on led_out. Bad frames are discarded.
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   ser_in     in   serial data, LSB first
//   latch      in   0 for one clk = end of frame, 1 = data bit valid
//   led_out    out  last committed pattern (WIDTH bits)
//   frame_ok   out  one-cycle pulse, led_out updated
//   len_err    out  one-cycle pulse, frame discarded (short or overrun)
//   synced     out  1 while in SHIFT state
// Optional build macro LED_RX_STATS_EN adds saturating 8-bit counters
//   frame_cnt (good frames) and err_cnt (discarded frames).
module led_sipo_rx #(
   parameter int               WIDTH       = 16,
   parameter int               SWAP_HALVES = 1,
   parameter logic [WIDTH-1:0] RESET_LEDS  = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ser_in,
   input  logic             latch,
   output logic [WIDTH-1:0] led_out,
   output logic             frame_ok,
   output logic             len_err,
   output logic             synced
`ifdef LED_RX_STATS_EN
   ,
   output logic [7:0]       frame_cnt,
   output logic [7:0]       err_cnt
`endif
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] FULL = CW'(WIDTH);

   typedef enum logic {SYNC, SHIFT} state_t;

   state_t           state, state_d;
   logic [WIDTH-1:0] sr, sr_d;
   logic [CW-1:0]    cnt, cnt_d;
   logic [WIDTH-1:0] led_d;
   logic             ok_d, err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= SYNC;
         sr       <= '0;
         cnt      <= '0;
         led_out  <= RESET_LEDS;
         frame_ok <= 1'b0;
         len_err  <= 1'b0;
      end else begin
         state    <= state_d;
         sr       <= sr_d;
         cnt      <= cnt_d;
         led_out  <= led_d;
         frame_ok <= ok_d;
         len_err  <= err_d;
      end
   end

   always_comb begin
      state_d = state;
      sr_d    = sr;
      cnt_d   = cnt;
      led_d   = led_out;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      case (state)
         SYNC: begin
            cnt_d = '0;
            if (!latch) state_d = SHIFT;
         end
         SHIFT: begin
            if (latch) begin
               if (cnt == FULL) begin
                  // overrun: drop the frame and wait for the next strobe
                  err_d   = 1'b1;
                  cnt_d   = '0;
                  state_d = SYNC;
               end else begin
                  sr_d  = {ser_in, sr[WIDTH-1:1]};
                  cnt_d = cnt + CW'(1);
               end
            end else begin
               cnt_d = '0;
               if (cnt == FULL) begin
                  ok_d = 1'b1;
                  if (SWAP_HALVES != 0)
                     led_d = {sr[WIDTH/2-1:0], sr[WIDTH-1:WIDTH/2]};
                  else
                     led_d = sr;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = SYNC;
      endcase
   end

   assign synced = (state == SHIFT);

`ifdef LED_RX_STATS_EN
   // counters step on the same edge the corresponding pulse is raised
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         if (ok_d && frame_cnt != 8'hFF) frame_cnt <= frame_cnt + 8'd1;
         if (err_d && err_cnt != 8'hFF)  err_cnt   <= err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_led_sipo_rx.sv
// tb_led_sipo_rx: directed and randomized frames for led_sipo_rx, compared
// every cycle against a frame-level reference model (bit queue per frame).
module tb_led_sipo_rx;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ser_in;
   logic          latch;
   logic [W-1:0]  led_out;
   logic          frame_ok;
   logic          len_err;
   logic          synced;
`ifdef LED_RX_STATS_EN
   logic [7:0]    frame_cnt;
   logic [7:0]    err_cnt;
`endif

   int total = 0;
   int bad   = 0;

   // reference model state
   bit          m_sync;
   bit          m_q[$];
   logic [15:0] m_led;
   bit          e_ok, e_err;
   int          m_fc, m_ec;

   led_sipo_rx #(
      .WIDTH       (W),
      .SWAP_HALVES (1),
      .RESET_LEDS  (16'h0000)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ser_in   (ser_in),
      .latch    (latch),
      .led_out  (led_out),
      .frame_ok (frame_ok),
      .len_err  (len_err),
      .synced   (synced)
`ifdef LED_RX_STATS_EN
      ,
      .frame_cnt (frame_cnt),
      .err_cnt   (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] swapw(input int unsigned w);
      return 16'(((w % 256) * 256) + (w / 256));
   endfunction

   task automatic chk_all();
      chk("led_out",  led_out,         m_led);
      chk("frame_ok", 16'(frame_ok),   16'(e_ok));
      chk("len_err",  16'(len_err),    16'(e_err));
      chk("synced",   16'(synced),     16'(m_sync));
`ifdef LED_RX_STATS_EN
      chk("frame_cnt", 16'(frame_cnt), 16'(m_fc));
      chk("err_cnt",   16'(err_cnt),   16'(m_ec));
`endif
   endtask

   task automatic model_reset();
      m_sync = 0;
      m_q.delete();
      m_led  = 16'h0000;
      e_ok   = 0;
      e_err  = 0;
      m_fc   = 0;
      m_ec   = 0;
   endtask

   // one clock: drive on negedge, predict, check #1 after posedge
   task automatic cyc(input logic s, input logic l);
      int unsigned acc;
      @(negedge clk);
      ser_in = s;
      latch  = l;
      e_ok   = 0;
      e_err  = 0;
      if (!l) begin
         if (!m_sync) m_sync = 1;
         else if (m_q.size() == W) begin
            acc = 0;
            for (int i = 0; i < W; i++) if (m_q[i]) acc += (32'd1 << i);
            m_led = swapw(acc);
            e_ok  = 1;
         end else e_err = 1;
         m_q.delete();
      end else if (m_sync) begin
         if (m_q.size() == W) begin
            e_err  = 1;
            m_sync = 0;
            m_q.delete();
         end else m_q.push_back(s);
      end
      if (e_ok  && m_fc < 255) m_fc++;
      if (e_err && m_ec < 255) m_ec++;
      @(posedge clk);
      #1;
      chk_all();
   endtask

   task automatic send_frame(input logic [15:0] word, input int n);
      for (int i = 0; i < n; i++) begin
         if (i < W) cyc(word[i], 1'b1);
         else       cyc(1'($urandom_range(0, 1)), 1'b1);
      end
      cyc(1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n  = 1'b0;
      latch  = 1'b1;
      ser_in = 1'b0;
      model_reset();
      #1;
      chk_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int n, sel;
      logic [15:0] w;
      rst_n  = 1'b0;
      latch  = 1'b1;
      ser_in = 1'b0;
      model_reset();
      #12;
      chk_all();
      @(negedge clk);
      rst_n = 1'b1;

      // sync, then one good frame
      cyc(1'b0, 1'b0);
      send_frame(16'h34A5, 16);
      chk("t2_led", led_out, 16'hA534);
      chk("t2_ok",  16'(frame_ok), 16'd1);

      // short frame then full frame
      send_frame(16'h1234, 9);
      chk("t3_err", 16'(len_err), 16'd1);
      chk("t3_led_kept", led_out, 16'hA534);
      send_frame(16'hFFFF, 16);
      chk("t3_led", led_out, 16'hFFFF);

      // overrun: 17th data sample triggers the error, further bits ignored
      for (int i = 0; i < 17; i++) cyc(1'($urandom_range(0, 1)), 1'b1);
      chk("t4_err",    16'(len_err), 16'd1);
      chk("t4_synced", 16'(synced),  16'd0);
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b0);

      // back-to-back frames at 17-clk spacing
      send_frame(16'h0001, 16);
      chk("t5_led0", led_out, 16'h0100);
      send_frame(16'h8000, 16);
      chk("t5_led1", led_out, 16'h0080);
      send_frame(16'h00FF, 16);
      chk("t5_led2", led_out, 16'hFF00);

      // randomized frames: mostly good, some short, some overrun
      repeat (40) begin
         w   = 16'($urandom_range(0, 65535));
         sel = $urandom_range(0, 9);
         if (sel < 7)      n = 16;
         else if (sel < 9) n = $urandom_range(0, 15);
         else              n = $urandom_range(17, 20);
         send_frame(w, n);
      end

      // reset mid-frame discards partial frame
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1);
      do_reset();
      chk("t1_led_rst", led_out, 16'h0000);

`ifdef LED_RX_STATS_EN
      cyc(1'b0, 1'b0);
      repeat (300) send_frame(16'($urandom_range(0, 65535)), 16);
      send_frame(16'h5555, 5);
      send_frame(16'hAAAA, 3);
      chk("t6_fcnt", 16'(frame_cnt), 16'h00FF);
      chk("t6_ecnt", 16'(err_cnt),   16'h0002);
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1);
      do_reset();
      chk("t6_fcnt_rst", 16'(frame_cnt), 16'h0000);
      chk("t6_ecnt_rst", 16'(err_cnt),   16'h0000);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
